// File: rtl/ysyx_22050019_axi_rd_arb.sv
// N-to-1 AXI-lite read arbiter: one whole AR+R transaction per grant.
// Define YSYX_22050019_ARB_RR_EN for round-robin, else highest index wins.
module ysyx_22050019_axi_rd_arb #(
  parameter int N      = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          m_arvalid,
  input  logic [N*ADDR_W-1:0]   m_araddr,
  output logic [N-1:0]          m_arready,
  output logic [N-1:0]          m_rvalid,
  output logic [DATA_W-1:0]     m_rdata,
  output logic [1:0]            m_rresp,
  input  logic [N-1:0]          m_rready,
  output logic                  s_arvalid,
  output logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_rready,
  output logic [$clog2(N)-1:0]  grant,
  output logic                  busy
);

  localparam int GW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   win;

`ifdef YSYX_22050019_ARB_RR_EN
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   rr_ptr_d;

  // Round-robin pick: first requester scanning cyclically from rr_ptr.
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N) j = j - N;
      if (m_arvalid[j]) win = GW'(j);
    end
    rr_ptr_d = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
  end
`else
  // Fixed priority pick: highest requesting index wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (m_arvalid[i]) win = GW'(i);
    end
  end
`endif

  // Transaction FSM: latch winner in IDLE, hold grant until R handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
`ifdef YSYX_22050019_ARB_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|m_arvalid) begin
            grant_q <= win;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (s_arvalid & s_arready) state_q <= DATA;
        end
        DATA: begin
          if (s_rvalid & s_rready) begin
            state_q  <= IDLE;
`ifdef YSYX_22050019_ARB_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational routing between the granted master and the slave.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    unique case (state_q)
      ADDR: begin
        s_arvalid          = m_arvalid[grant_q];
        s_araddr           = m_araddr[int'(grant_q)*ADDR_W +: ADDR_W];
        m_arready[grant_q] = s_arready;
      end
      DATA: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
      end
      default: ;
    endcase
  end

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arb.sv
// Directed bench for ysyx_22050019_axi_rd_arb (N=2, 64-bit).
// Expectations follow YSYX_22050019_ARB_RR_EN when it is defined.
module tb_ysyx_22050019_axi_rd_arb;

  logic          clk;
  logic          rst_n;
  logic [1:0]    m_arvalid;
  logic [127:0]  m_araddr;
  logic [1:0]    m_arready;
  logic [1:0]    m_rvalid;
  logic [63:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic [1:0]    m_rready;
  logic          s_arvalid;
  logic [63:0]   s_araddr;
  logic          s_arready;
  logic          s_rvalid;
  logic [63:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rready;
  logic          grant;
  logic          busy;

  int nchk;
  int nerr;

  ysyx_22050019_axi_rd_arb #(
    .N(2), .ADDR_W(64), .DATA_W(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr),
    .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rready(m_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr),
    .s_arready(s_arready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rready(s_rready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A1 = 64'h0000_0000_9000_0000;

  logic g;

  initial begin
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    m_arvalid = 2'b11;
    m_araddr = {A1, A0};
    m_rready = 2'b11;
    s_arready = 1'b0;
    s_rvalid = 1'b0;
    s_rdata = '0;
    s_rresp = 2'b00;

    // reset held with both requesting
    repeat (2) cyc();
    check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst_s_rready", 64'(s_rready), 64'd0);
    check("rst_m_arready", 64'(m_arready), 64'd0);
    check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_s_araddr", s_araddr, 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    rst_n = 1'b1;
    cyc();
`ifdef YSYX_22050019_ARB_RR_EN
    check("rel_grant", 64'(grant), 64'd0);
`else
    check("rel_grant", 64'(grant), 64'd1);
`endif
    check("rel_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    m_arvalid = 2'b00;
    #1;
    check("rst_async_busy", 64'(busy), 64'd0);
    cyc();
    rst_n = 1'b1;

    // single IFU read, zero-wait slave
    s_arready = 1'b1;
    s_rvalid = 1'b1;
    s_rdata = 64'h13;
    m_arvalid = 2'b01;
    #1;
    check("ifu_T_busy", 64'(busy), 64'd0);
    check("ifu_T_rvalid_ignored", 64'(m_rvalid), 64'd0);
    cyc();
    check("ifu_T1_arvalid", 64'(s_arvalid), 64'd1);
    check("ifu_T1_araddr", s_araddr, A0);
    check("ifu_T1_arready", 64'(m_arready), 64'b01);
    @(posedge clk);
    #1 m_arvalid = 2'b00;
    @(negedge clk);
    check("ifu_T2_rvalid", 64'(m_rvalid), 64'b01);
    check("ifu_T2_rdata", m_rdata, 64'h13);
    check("ifu_T2_rready", 64'(s_rready), 64'd1);
    cyc();
    check("ifu_T3_busy", 64'(busy), 64'd0);

    // contention, both requesting continuously
    m_arvalid = 2'b11;
    g = 1'b1;
    for (int t = 0; t < 4; t++) begin
      s_rdata = 64'h100 + 64'(t);
      check("cont_idle_busy", 64'(busy), 64'd0);
      cyc();
      check("cont_grant", 64'(grant), 64'(g));
      check("cont_araddr", s_araddr, g ? A1 : A0);
      check("cont_arready", 64'(m_arready), g ? 64'b10 : 64'b01);
      cyc();
      check("cont_rvalid", 64'(m_rvalid), g ? 64'b10 : 64'b01);
      check("cont_rdata", m_rdata, 64'h100 + 64'(t));
      cyc();
`ifdef YSYX_22050019_ARB_RR_EN
      g = ~g;
`endif
    end
    m_arvalid = 2'b00;
    cyc();

    // slave stalls; stray s_rvalid during ADDR
    s_arready = 1'b0;
    s_rvalid = 1'b1;
    m_arvalid = 2'b01;
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("stall_ar_grant", 64'(grant), 64'd0);
      check("stall_ar_valid", 64'(s_arvalid), 64'd1);
      check("stall_ar_ready", 64'(m_arready), 64'd0);
      check("stall_ar_rready", 64'(s_rready), 64'd0);
      check("stall_ar_rvalid", 64'(m_rvalid), 64'd0);
      cyc();
    end
    // granted master drops its request mid-ADDR
    m_arvalid = 2'b00;
    #1;
    check("drop_arvalid", 64'(s_arvalid), 64'd0);
    cyc();
    check("drop_busy", 64'(busy), 64'd1);
    check("drop_grant", 64'(grant), 64'd0);
    m_arvalid = 2'b01;
    s_arready = 1'b1;
    #1;
    check("stall_ar_hs", 64'(m_arready), 64'b01);
    @(posedge clk);
    #1;
    s_arready = 1'b0;
    s_rvalid = 1'b0;
    m_arvalid = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("stall_r_grant", 64'(grant), 64'd0);
      check("stall_r_rvalid", 64'(m_rvalid), 64'd0);
      check("stall_r_arready", 64'(m_arready), 64'd0);
      check("stall_r_busy", 64'(busy), 64'd1);
      cyc();
    end
    s_rvalid = 1'b1;
    s_rdata = 64'hdead_beef;
    #1;
    check("stall_r_hs", 64'(m_rvalid), 64'b01);
    check("stall_r_data", m_rdata, 64'hdead_beef);
    cyc();
    check("stall_idle", 64'(busy), 64'd0);
    cyc();
    check("pend_grant", 64'(grant), 64'd1);
    check("pend_araddr", s_araddr, A1);

    // reset asserted in DATA with s_rvalid low
    s_rvalid = 1'b0;
    s_arready = 1'b1;
    cyc();
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_rready", 64'(s_rready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rready", 64'(s_rready), 64'd0);
    check("mid_rst_grant", 64'(grant), 64'd0);
    cyc();
    rst_n = 1'b1;
    s_rvalid = 1'b1;
    s_rdata = 64'h55;
    cyc();
    check("post_grant", 64'(grant), 64'd1);
    check("post_arvalid", 64'(s_arvalid), 64'd1);
    cyc();
    check("post_rvalid", 64'(m_rvalid), 64'b10);
    check("post_rdata", m_rdata, 64'h55);
    m_arvalid = 2'b00;
    cyc();
    check("post_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
